// File: rtl/rv32i_issue_stage.sv
// RV32I issue stage: decodes OP, OP-IMM, LUI and AUIPC into an ALU bundle
// (operands, op code, destination, write-back enable, illegal flag) and
// presents it through a registered valid/ready output.
// Optional feature: define RV32I_ISSUE_SKID_EN to add a one-entry skid buffer.
// That makes in_ready a pure flop output and keeps full throughput.
module rv32i_issue_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1_data,
  input  logic [31:0] in_rs2_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_operand_a,
  output logic [31:0] out_operand_b,
  output logic [3:0]  out_alu_op,
  output logic [4:0]  out_rd,
  output logic        out_wb_en,
  output logic        out_illegal
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_SLL  = 4'b0010,
    ALU_SLT  = 4'b0011,
    ALU_SLTU = 4'b0100,
    ALU_XOR  = 4'b0101,
    ALU_SRL  = 4'b0110,
    ALU_SRA  = 4'b0111,
    ALU_OR   = 4'b1000,
    ALU_AND  = 4'b1001
  } alu_op_e;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    alu_op_e     op;
    logic [4:0]  rd;
    logic        wb_en;
    logic        illegal;
  } bundle_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] shamt;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign funct7 = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_u  = {in_instr[31:12], 12'h000};
  assign shamt  = {27'd0, in_instr[24:20]};

  // funct3 -> ALU op for the base (funct7 = 0) encodings shared by OP and OP-IMM
  function automatic alu_op_e base_op(input logic [2:0] f3);
    case (f3)
      3'b000:  base_op = ALU_ADD;
      3'b001:  base_op = ALU_SLL;
      3'b010:  base_op = ALU_SLT;
      3'b011:  base_op = ALU_SLTU;
      3'b100:  base_op = ALU_XOR;
      3'b101:  base_op = ALU_SRL;
      3'b110:  base_op = ALU_OR;
      default: base_op = ALU_AND;
    endcase
  endfunction

  bundle_t dec;
  logic    dec_legal;

  // Decode the incoming instruction into an issue bundle
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    dec       = '0;
    dec.rd    = rd;
    dec_legal = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec.a = in_rs1_data;
        dec.b = in_rs2_data;
        if (funct7 == F7_BASE) begin
          dec_legal = 1'b1;
          dec.op    = base_op(funct3);
        end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
          dec_legal = 1'b1;
          dec.op    = ALU_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
          dec_legal = 1'b1;
          dec.op    = ALU_SRA;
        end
      end
      OPC_OP_IMM: begin
        dec.a = in_rs1_data;
        dec.b = imm_i;
        case (funct3)
          3'b001: begin
            dec.b = shamt;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec.op    = ALU_SLL;
            end
          end
          3'b101: begin
            dec.b = shamt;
            if (funct7 == F7_BASE) begin
              dec_legal = 1'b1;
              dec.op    = ALU_SRL;
            end else if (funct7 == F7_ALT) begin
              dec_legal = 1'b1;
              dec.op    = ALU_SRA;
            end
          end
          default: begin
            dec_legal = 1'b1;
            dec.op    = base_op(funct3);
          end
        endcase
      end
      OPC_LUI: begin
        dec_legal = 1'b1;
        dec.b     = imm_u;
      end
      OPC_AUIPC: begin
        dec_legal = 1'b1;
        dec.a     = in_pc;
        dec.b     = imm_u;
      end
      default: ;
    endcase
    // Unsupported encodings issue a harmless ADD of zeros with no write-back
    if (!dec_legal) begin
      dec.a  = '0;
      dec.b  = '0;
      dec.op = ALU_ADD;
    end
    dec.illegal = !dec_legal;
    dec.wb_en   = dec_legal && (rd != 5'd0);
  end

  bundle_t out_q;
  logic    out_valid_q;
  logic    in_fire;
  logic    out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid_q && out_ready;

`ifdef RV32I_ISSUE_SKID_EN
  bundle_t skid_q;
  logic    skid_full_q;
  logic    in_ready_q;

  assign in_ready = in_ready_q;

  // Output register plus one-entry skid; in_ready is registered as !skid_full
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bundle and skid registers are reset too, so every out_* reads 0 during reset.
      out_q       <= '0;
      out_valid_q <= 1'b0;
      skid_q      <= '0;
      skid_full_q <= 1'b0;
      in_ready_q  <= 1'b0;
    end else if (skid_full_q) begin
      // Input is stalled; drain the skid into the output slot when it frees up
      if (out_fire) begin
        out_q       <= skid_q;
        skid_full_q <= 1'b0;
        in_ready_q  <= 1'b1;
      end
    end else if (in_fire) begin
      if (out_valid_q && !out_ready) begin
        skid_q      <= dec;
        skid_full_q <= 1'b1;
        in_ready_q  <= 1'b0;
      end else begin
        out_q       <= dec;
        out_valid_q <= 1'b1;
        in_ready_q  <= 1'b1;
      end
    end else begin
      if (out_fire) out_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  // Single output register: load on input transfer, clear valid on a lone output transfer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the bundle register is reset too, so every out_* reads 0 during reset.
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else if (in_fire) begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
      out_q       <= dec;
      out_valid_q <= 1'b1;
    end else if (out_fire) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid     = out_valid_q;
  assign out_operand_a = out_q.a;
  assign out_operand_b = out_q.b;
  assign out_alu_op    = out_q.op;
  assign out_rd        = out_q.rd;
  assign out_wb_en     = out_q.wb_en;
  assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_rv32i_issue_stage.sv
// Self-checking bench for rv32i_issue_stage: a queue-based reference model
// tracks accepted instructions and checks the output bundle every cycle,
// plus directed literal checks for the reference instructions.
module tb_rv32i_issue_stage;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [4:0]  rd;
    logic        wb;
    logic        ill;
  } bundle_t;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_operand_a;
  logic [31:0] out_operand_b;
  logic [3:0]  out_alu_op;
  logic [4:0]  out_rd;
  logic        out_wb_en;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;

  bundle_t exp_q[$];
  bundle_t dut_b;
  logic    edge_seen;

  assign dut_b = {out_operand_a, out_operand_b, out_alu_op, out_rd, out_wb_en, out_illegal};

  rv32i_issue_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_instr(in_instr),
    .in_pc(in_pc),
    .in_rs1_data(in_rs1_data),
    .in_rs2_data(in_rs2_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_operand_a(out_operand_a),
    .out_operand_b(out_operand_b),
    .out_alu_op(out_alu_op),
    .out_rd(out_rd),
    .out_wb_en(out_wb_en),
    .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference decode written from the ISA rules: ALT funct7 adds one to the
  // base op code (ADD->SUB, SRL->SRA); shifts take shamt as operand b.
  function automatic bundle_t model(input logic [31:0] instr, input logic [31:0] pc,
                                    input logic [31:0] rs1, input logic [31:0] rs2);
    bundle_t    m;
    logic [3:0] opmap [8];
    logic       legal;
    logic       alt;
    logic       shift;
    logic [6:0] opc;
    logic [6:0] f7;
    logic [2:0] f3;
    opmap = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    opc   = instr[6:0];
    f3    = instr[14:12];
    f7    = instr[31:25];
    alt   = (f7 == 7'h20);
    shift = (f3 == 3'd1) || (f3 == 3'd5);
    m     = '0;
    legal = 1'b0;
    case (opc)
      7'h33: begin
        legal = (f7 == 7'h00) || (alt && (f3 == 3'd0 || f3 == 3'd5));
        m.a   = rs1;
        m.b   = rs2;
        m.op  = opmap[f3] + {3'b000, alt};
      end
      7'h13: begin
        legal = !shift || (f7 == 7'h00) || (alt && f3 == 3'd5);
        m.a   = rs1;
        m.b   = shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
        m.op  = opmap[f3] + {3'b000, shift && alt};
      end
      7'h37: begin
        legal = 1'b1;
        m.b   = {instr[31:12], 12'h000};
      end
      7'h17: begin
        legal = 1'b1;
        m.a   = pc;
        m.b   = {instr[31:12], 12'h000};
      end
      default: ;
    endcase
    if (!legal) begin
      m.a  = '0;
      m.b  = '0;
      m.op = '0;
    end
    m.rd  = instr[11:7];
    m.ill = !legal;
    m.wb  = legal && (instr[11:7] != 5'd0);
    return m;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int          k;
    int          j;
    r = $urandom;
    k = $urandom_range(0, 9);
    if (k <= 3)      r[6:0] = 7'h33;
    else if (k <= 6) r[6:0] = 7'h13;
    else if (k == 7) r[6:0] = 7'h37;
    else if (k == 8) r[6:0] = 7'h17;
    j = $urandom_range(0, 3);
    if (j <= 1)      r[31:25] = 7'h00;
    else if (j == 2) r[31:25] = 7'h20;
    if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_seen <= 1'b0;
    else        edge_seen <= 1'b1;
  end

  // Per-cycle compare against the reference queue, then account for transfers
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      check("rst_out_valid", out_valid, 0);
      check("rst_bundle", dut_b, 0);
`ifdef RV32I_ISSUE_SKID_EN
      check("rst_in_ready", in_ready, 0);
`endif
    end else begin
      check("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid && exp_q.size() > 0) check("bundle", dut_b, exp_q[0]);
`ifdef RV32I_ISSUE_SKID_EN
      check("in_ready", in_ready, edge_seen && (exp_q.size() < 2));
`else
      check("in_ready", in_ready, !out_valid || out_ready);
`endif
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
      if (in_valid && in_ready) exp_q.push_back(model(in_instr, in_pc, in_rs1_data, in_rs2_data));
    end
  end

  // Drive one instruction with out_ready=1; returns at the negedge where its bundle is visible
  task automatic issue_one(input logic [31:0] i, input logic [31:0] pc,
                           input logic [31:0] r1, input logic [31:0] r2);
    int n;
    n = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; in_instr = i; in_pc = pc; in_rs1_data = r1; in_rs2_data = r2;
    out_ready = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL issue_timeout: in_ready stayed 0 for %0d cycles", n);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    bundle_t     m;
    logic [4:0]  rds[$];
    int          n_acc;
    int          acc2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_rs1_data = '0; in_rs2_data = '0;
    #22 rst_n = 1'b1;
`ifdef RV32I_ISSUE_SKID_EN
    #1 check("release_in_ready_low", in_ready, 0);
    @(posedge clk); #1;
    check("first_edge_in_ready", in_ready, 1);
`endif

    // Pin the model with hand-derived values
    m = model(32'h4040D293, 32'h0, 32'h80000000, 32'h0);
    check("model_srai_op", m.op, 4'b0111);
    check("model_srai_b", m.b, 32'd4);
    m = model(32'h00002083, 32'h0, 32'h1, 32'h2);
    check("model_load_ill", m.ill, 1);

    // ADD x3,x1,x2
    issue_one(32'h002081B3, 32'h100, 32'd5, 32'd7);
    check("add_valid", out_valid, 1);
    check("add_op", out_alu_op, 4'b0000);
    check("add_a", out_operand_a, 32'd5);
    check("add_b", out_operand_b, 32'd7);
    check("add_rd", out_rd, 5'd3);
    check("add_wb", out_wb_en, 1);

    // SRAI x5,x1,4
    issue_one(32'h4040D293, 32'h104, 32'h80000000, 32'h0);
    check("srai_op", out_alu_op, 4'b0111);
    check("srai_a", out_operand_a, 32'h80000000);
    check("srai_b", out_operand_b, 32'd4);
    check("srai_rd", out_rd, 5'd5);

    // LUI x7,0x12345
    issue_one(32'h123453B7, 32'h108, 32'hDEADBEEF, 32'h1);
    check("lui_a", out_operand_a, 32'd0);
    check("lui_b", out_operand_b, 32'h12345000);
    check("lui_op", out_alu_op, 4'b0000);
    check("lui_wb", out_wb_en, 1);

    // AUIPC x1,0xABCDE
    issue_one(32'hABCDE097, 32'h00001000, 32'h5, 32'h6);
    check("auipc_a", out_operand_a, 32'h00001000);
    check("auipc_b", out_operand_b, 32'hABCDE000);

    // Load (unsupported) and ADD with rd=0
    issue_one(32'h00002083, 32'h10C, 32'h11, 32'h22);
    check("load_ill", out_illegal, 1);
    check("load_wb", out_wb_en, 0);
    check("load_a", out_operand_a, 32'd0);
    issue_one(32'h00208033, 32'h110, 32'h11, 32'h22);
    check("rd0_ill", out_illegal, 0);
    check("rd0_wb", out_wb_en, 0);

    // Back-pressure: out_ready low for 3 cycles while streaming 2 instructions
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    n_acc = 0;
    acc2  = -10;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      out_ready   = (c >= 3);
      in_valid    = (n_acc < 2);
      in_instr    = (n_acc == 0) ? 32'h00208533 : 32'h002085B3;
      in_rs1_data = 32'd100 + c;
      in_rs2_data = 32'd200;
      @(negedge clk);
      if (c == 1 || c == 2) check("hold_rd", out_rd, 5'd10);
`ifdef RV32I_ISSUE_SKID_EN
      if (c == acc2 + 1) check("skid_in_ready_drop", in_ready, 0);
`else
      if (c == 1) check("noskid_in_ready_drop", in_ready, 0);
`endif
      if (in_valid && in_ready) begin
        n_acc++;
        if (n_acc == 2) acc2 = c;
      end
      if (out_valid && out_ready) rds.push_back(out_rd);
    end
    check("stream_count", rds.size(), 2);
    if (rds.size() >= 2) begin
      check("stream_first", rds[0], 5'd10);
      check("stream_second", rds[1], 5'd11);
    end

    // Reset while a bundle is held
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00208633;
    in_rs1_data = 32'd1; in_rs2_data = 32'd2;
    @(negedge clk);
    check("r36_accept", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("r36_held_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("r36_drop_valid", out_valid, 0);
    check("r36_drop_rd", out_rd, 5'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
`ifdef RV32I_ISSUE_SKID_EN
    #1 check("r36_release_in_ready", in_ready, 0);
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("r36_no_emit", out_valid, 0);
    end

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      in_valid    = ($urandom_range(0, 3) != 0);
      in_instr    = rand_instr();
      in_pc       = $urandom;
      in_rs1_data = $urandom;
      in_rs2_data = $urandom;
      out_ready   = (c % 200 < 100) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 2) == 0);
    end

    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_issue_stage.md
RV32I_ISSUE_STAGE -- requirements
Module: rv32i_issue_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock, rising-edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-003 SHALL have port in_valid, input, 1 bit: upstream instruction valid.
REQ-004 SHALL have port in_ready, output, 1 bit: stage accepts the upstream instruction.
REQ-005 SHALL have port in_instr, input, 32 bits: instruction word.
REQ-006 SHALL have port in_pc, input, 32 bits: address of the instruction.
REQ-007 SHALL have ports in_rs1_data and in_rs2_data, input, 32 bits each: register-file read data.
REQ-008 SHALL have port out_valid, output, 1 bit: issue bundle valid.
REQ-009 SHALL have port out_ready, input, 1 bit: execute stage accepts the bundle.
REQ-010 SHALL have ports out_operand_a and out_operand_b, output, 32 bits each: ALU operands.
REQ-011 SHALL have port out_alu_op, output, 4 bits: ALU op code. Encodings: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001.
REQ-012 SHALL have port out_rd, output, 5 bits: destination register index.
REQ-013 SHALL have port out_wb_en, output, 1 bit: result is to be written back.
REQ-014 SHALL have port out_illegal, output, 1 bit: instruction is unsupported.

Function
REQ-015 SHALL transfer on an edge when valid and ready are both high; a transfer on each side SHALL take exactly one cycle.
REQ-016 SHALL register all out_* signals, so a bundle appears one cycle after its input transfer; there SHALL be no combinational in->out path except in_ready.
REQ-017 SHALL hold the out_* bundle stable while out_valid=1 and out_ready=0.
REQ-018 OP (opcode 0110011) SHALL decode as follows:
- operand_a=rs1_data, operand_b=rs2_data.
- funct7 0000000 maps funct3 000-111 to ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND.
- funct7 0100000 with funct3 000 gives SUB; with funct3 101 gives SRA.
REQ-019 OP-IMM (opcode 0010011) SHALL decode as follows:
- operand_a=rs1_data, operand_b=sign-extended instr[31:20].
- Mapping is the same as OP but without SUB.
- SLLI/SRLI require funct7 0000000; SRAI requires funct7 0100000.
- For shifts, operand_b=zero-extended instr[24:20].
REQ-020 LUI (0110111) SHALL issue operand_a=0, operand_b={instr[31:12],12'h0}, op ADD.
REQ-021 AUIPC (0010111) SHALL issue operand_a=in_pc, operand_b={instr[31:12],12'h0}, op ADD.
REQ-022 Any other opcode or funct7/funct3 combination SHALL issue out_illegal=1, op ADD, operands 0, out_wb_en=0.
REQ-023 out_wb_en SHALL be 1 for legal instructions with rd!=0, and 0 when rd=0.
REQ-024 in_ready SHALL be (!out_valid || out_ready) when the skid buffer is compiled out.
REQ-025 Simultaneous input and output transfers SHALL replace the bundle with no bubble.
REQ-026 out_valid SHALL fall only when the output transfers and no new input transfers in the same cycle.

Reset
REQ-027 While rst_n=0, out_valid SHALL be 0 and all other out_* SHALL be 0.
REQ-028 With the skid buffer compiled in, in_ready SHALL be 0 during reset and 1 on the first edge after reset release.
REQ-029 A reset asserted mid-stream SHALL drop all buffered bundles without emitting them.

Configuration
REQ-030 Macro RV32I_ISSUE_SKID_EN SHALL control a one-entry skid buffer.
- Defined: in_ready is driven directly from a flop as !skid_full. A bundle accepted while out_valid=1 and out_ready=0 is held in the skid. Skid contents are presented next, in order. Full throughput is kept.
- Undefined: there is no skid, and REQ-024 applies.

Verification
REQ-031 Bench SHALL drive ADD x3,x1,x2 (0x002081B3) with rs1=5 and rs2=7. Required: next cycle op=0000, a=5, b=7, rd=3, wb_en=1.
REQ-032 Bench SHALL drive SRAI x5,x1,4 (0x4040D293) with rs1=0x80000000. Required: op=0111, a=0x80000000, b=4, rd=5.
REQ-033 Bench SHALL drive LUI x7,0x12345 (0x123453B7). Required: a=0, b=0x12345000, op=0000, wb_en=1.
REQ-034 Bench SHALL drive opcode 0000011 (load) and, separately, ADD with rd=0. Required: illegal=1 and wb_en=0 for the load; illegal=0 and wb_en=0 for rd=0.
REQ-035 Bench SHALL hold out_ready=0 for 3 cycles while streaming 2 instructions. Required:
- Output is stable.
- With skid: in_ready drops after the 2nd accept.
- Both bundles emerge in order with no loss or duplication.
REQ-036 Bench SHALL pulse rst_n=0 while out_valid=1. Required: out_valid=0 immediately, and the held bundle is never emitted.
